// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage controller and the hazard detector.
// Opcode width, the opcode constants both sides decode, and the pipeline state encoding.
package pipe_pkg;

    localparam int OPW = 7;

    localparam logic [OPW-1:0] OP_BUBBLE = 7'b0000000;
    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_DRAIN = 2'b11
    } pipe_state_t;

    function automatic logic is_bubble(input logic [OPW-1:0] op);
        return op == OP_BUBBLE;
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Instruction-source handshake into the pipeline stage controller.
// A transfer happens on a rising edge where instr_valid and instr_ready are both high.
interface pipe_stage_ctrl_if;
    import pipe_pkg::*;

    logic           instr_valid;
    logic [OPW-1:0] instr_opcode;
    logic           instr_ready;

    modport master (
        output instr_valid,
        output instr_opcode,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        output instr_ready
    );

endinterface

// File: rtl/pipe_stage_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// IF/ID/EX/MEM/WB opcode pipeline with stall freeze, taken-branch flush and event counters.
//
// state  | meaning
// IDLE   | pipeline empty, no instruction offered
// RUN    | source is offering instructions
// STALL  | hazard stall applied this cycle (IF/ID frozen, EX bubble)
// DRAIN  | source idle, older opcodes still in flight
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_stage_ctrl_if.slave    src,
    input  logic                stall,
    input  logic                branch_taken,
    output logic [OPW-1:0]      fetch,
    output logic [OPW-1:0]      decode,
    output logic [OPW-1:0]      exec,
    output logic [OPW-1:0]      mem,
    output logic [OPW-1:0]      wb,
    output logic [1:0]          pipeline_state,
    output logic [CNTW-1:0]     stall_cnt,
    output logic [CNTW-1:0]     flush_cnt,
    output logic [CNTW-1:0]     retire_cnt
);

    logic           flush;
    logic           hold;
    logic           xfer;
    logic           retire;
    logic [OPW-1:0] fetch_nxt;
    logic [OPW-1:0] decode_nxt;
    logic [OPW-1:0] exec_nxt;
    logic [OPW-1:0] mem_nxt;
    logic [OPW-1:0] wb_nxt;
    logic           empty_nxt;

    pipe_state_t    state;
    pipe_state_t    state_nxt;

    // A raw branch_taken still opens instr_ready even when exec is not a branch.
    assign src.instr_ready = !stall || branch_taken;

    assign flush  = branch_taken && (exec == OP_BRANCH);
    assign hold   = stall && !flush;
    assign xfer   = src.instr_valid && src.instr_ready;
    assign retire = !is_bubble(mem);

    // EX always takes a bubble unless advancing; MEM/WB shift in every case.
    // On a flush the branch itself sits in exec, so mem taking exec keeps it.
    always_comb begin
        fetch_nxt  = fetch;
        decode_nxt = decode;
        exec_nxt   = OP_BUBBLE;
        mem_nxt    = exec;
        wb_nxt     = mem;
        if (flush) begin
            fetch_nxt  = OP_BUBBLE;
            decode_nxt = OP_BUBBLE;
        end else if (!hold) begin
            fetch_nxt  = xfer ? src.instr_opcode : OP_BUBBLE;
            decode_nxt = fetch;
            exec_nxt   = decode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch  <= OP_BUBBLE;
            decode <= OP_BUBBLE;
            exec   <= OP_BUBBLE;
            mem    <= OP_BUBBLE;
            wb     <= OP_BUBBLE;
        end else begin
            fetch  <= fetch_nxt;
            decode <= decode_nxt;
            exec   <= exec_nxt;
            mem    <= mem_nxt;
            wb     <= wb_nxt;
        end
    end

    assign empty_nxt = is_bubble(fetch_nxt) && is_bubble(decode_nxt) && is_bubble(exec_nxt)
                    && is_bubble(mem_nxt) && is_bubble(wb_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state depends only on the post-update stage contents and this cycle's inputs.
    always_comb begin
        state_nxt = state;
        if (hold) begin
            state_nxt = ST_STALL;
        end else if (empty_nxt && !src.instr_valid) begin
            state_nxt = ST_IDLE;
        end else if (src.instr_valid) begin
            state_nxt = ST_RUN;
        end else begin
            state_nxt = ST_DRAIN;
        end
    end

    assign pipeline_state = state;

    sat_counter #(.CNTW(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold),
        .count (stall_cnt)
    );

    sat_counter #(.CNTW(CNTW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .count (flush_cnt)
    );

    sat_counter #(.CNTW(CNTW)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (retire_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios plus random traffic against a reference model.
// Two instances (16-bit and 4-bit counters) share the same stimulus.
module tb_pipe_stage_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           valid;
    logic [OPW-1:0] opcode;
    logic           stall;
    logic           branch_taken;

    pipe_stage_ctrl_if if16 ();
    pipe_stage_ctrl_if if4 ();
    assign if16.instr_valid  = valid;
    assign if16.instr_opcode = opcode;
    assign if4.instr_valid   = valid;
    assign if4.instr_opcode  = opcode;

    logic [OPW-1:0] f16, d16, e16, m16, w16;
    logic [1:0]     ps16;
    logic [15:0]    sc16, fc16, rc16;
    logic [OPW-1:0] f4, d4, e4, m4, w4;
    logic [1:0]     ps4;
    logic [3:0]     sc4, fc4, rc4;

    pipe_stage_ctrl #(.CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .src(if16.slave), .stall(stall), .branch_taken(branch_taken),
        .fetch(f16), .decode(d16), .exec(e16), .mem(m16), .wb(w16), .pipeline_state(ps16),
        .stall_cnt(sc16), .flush_cnt(fc16), .retire_cnt(rc16)
    );

    pipe_stage_ctrl #(.CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .src(if4.slave), .stall(stall), .branch_taken(branch_taken),
        .fetch(f4), .decode(d4), .exec(e4), .mem(m4), .wb(w4), .pipeline_state(ps4),
        .stall_cnt(sc4), .flush_cnt(fc4), .retire_cnt(rc4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: stage contents as a plain array, counters as unbounded event tallies.
    int unsigned m_st[5];
    int unsigned m_state;
    int unsigned m_ns, m_nf, m_nr;

    function automatic int unsigned cap(input int unsigned n, input int unsigned lim);
        return (n > lim) ? lim : n;
    endfunction

    function automatic void model_reset();
        foreach (m_st[i]) m_st[i] = 0;
        m_state = 0;
        m_ns = 0;
        m_nf = 0;
        m_nr = 0;
    endfunction

    function automatic void model_step(input bit v, input int unsigned op, input bit st, input bit bt);
        int unsigned old[5];
        bit          fl, xf, empty;
        old = m_st;
        fl  = bt && (old[2] == 'h63);
        xf  = v && (!st || bt);
        if (old[3] != 0) m_nr++;
        if (fl) begin
            m_st = '{0, 0, 0, old[2], old[3]};
            m_nf++;
        end else if (st) begin
            m_st = '{old[0], old[1], 0, old[2], old[3]};
            m_ns++;
        end else begin
            m_st = '{xf ? op : 0, old[0], old[1], old[2], old[3]};
        end
        empty = 1'b1;
        foreach (m_st[i]) if (m_st[i] != 0) empty = 1'b0;
        if (st && !fl)       m_state = 2;
        else if (empty && !v) m_state = 0;
        else if (v)          m_state = 1;
        else                 m_state = 3;
    endfunction

    task automatic check_all();
        chk("fetch",    32'(f16), m_st[0]);
        chk("decode",   32'(d16), m_st[1]);
        chk("exec",     32'(e16), m_st[2]);
        chk("mem",      32'(m16), m_st[3]);
        chk("wb",       32'(w16), m_st[4]);
        chk("state",    32'(ps16), m_state);
        chk("stall_cnt",  32'(sc16), cap(m_ns, 65535));
        chk("flush_cnt",  32'(fc16), cap(m_nf, 65535));
        chk("retire_cnt", 32'(rc16), cap(m_nr, 65535));
        chk("fetch4",   32'(f4), m_st[0]);
        chk("wb4",      32'(w4), m_st[4]);
        chk("state4",   32'(ps4), m_state);
        chk("stall_cnt4",  32'(sc4), cap(m_ns, 15));
        chk("flush_cnt4",  32'(fc4), cap(m_nf, 15));
        chk("retire_cnt4", 32'(rc4), cap(m_nr, 15));
        chk("decode4",  32'(d4), m_st[1]);
        chk("exec4",    32'(e4), m_st[2]);
        chk("mem4",     32'(m4), m_st[3]);
    endtask

    // Called away from the clock edge; applies inputs, checks ready, clocks once, checks all.
    task automatic step(input bit v, input int unsigned op, input bit st, input bit bt);
        valid        = v;
        opcode       = OPW'(op);
        stall        = st;
        branch_taken = bt;
        #1;
        chk("instr_ready", 32'(if16.instr_ready), (!st || bt) ? 1 : 0);
        model_step(v, op, st, bt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic async_reset(input bit st);
        valid        = 1'b0;
        branch_taken = 1'b0;
        stall        = st;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("ready_in_reset", 32'(if16.instr_ready), st ? 0 : 1);
        rst_n = 1'b1;
        stall = 1'b0;
        #1;
    endtask

    initial begin
        bit           last_v, last_rdy, v, st, bt;
        int unsigned  last_op, op;
        int unsigned  op_tab[6];

        op_tab = '{'h33, 'h13, 'h23, 'h03, 'h63, 'h00};
        rst_n = 1'b0;
        valid = 1'b0;
        opcode = '0;
        stall = 1'b0;
        branch_taken = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        #1;

        // Streaming three opcodes with no stalls, then draining.
        step(1, 'h33, 0, 0);
        chk("stream_state_run", 32'(ps16), 1);
        step(1, 'h13, 0, 0);
        step(1, 'h23, 0, 0);
        step(0, 0, 0, 0);
        chk("stream_state_drain", 32'(ps16), 3);
        step(0, 0, 0, 0);
        chk("stream_wb_33", 32'(w16), 'h33);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("stream_retired", 32'(rc16), 3);
        chk("stream_state_idle", 32'(ps16), 0);

        // Single stall with decode=33, exec=03.
        async_reset(0);
        step(1, 'h03, 0, 0);
        step(1, 'h33, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("stall_decode", 32'(d16), 'h33);
        chk("stall_exec", 32'(e16), 0);
        chk("stall_mem", 32'(m16), 'h03);
        chk("stall_state", 32'(ps16), 2);
        chk("stall_cnt_one", 32'(sc16), 1);
        step(0, 0, 0, 0);
        chk("after_stall_exec", 32'(e16), 'h33);

        // Taken branch in exec overrides stall and drops the accepted opcode.
        async_reset(0);
        step(1, 'h63, 0, 0);
        step(1, 'h13, 0, 0);
        step(1, 'h23, 0, 0);
        step(1, 'h33, 1, 1);
        chk("flush_fetch", 32'(f16), 0);
        chk("flush_exec", 32'(e16), 0);
        chk("flush_mem", 32'(m16), 'h63);
        chk("flush_cnt_one", 32'(fc16), 1);
        step(0, 0, 0, 0);

        // branch_taken without a branch in exec is a normal advance.
        async_reset(0);
        step(1, 'h33, 0, 0);
        step(1, 'h13, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("unq_mem", 32'(m16), 'h33);
        chk("unq_flush_cnt", 32'(fc16), 0);

        // Counter saturation on the 4-bit instance, then reset mid-stall.
        async_reset(0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        chk("sat_stall4", 32'(sc4), 15);
        chk("sat_stall16", 32'(sc16), 20);
        step(1, 'h13, 0, 0);
        step(1, 'h23, 1, 0);
        async_reset(1);

        // Random traffic; opcode held while offered but not accepted.
        last_v = 0;
        last_rdy = 1;
        last_op = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 3) == 0);
            bt = (m_st[2] == 'h63) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            if (last_v && !last_rdy) begin
                op = last_op;
                v  = ($urandom_range(0, 5) != 0);
            end else begin
                op = (($urandom_range(0, 6)) == 6) ? $urandom_range(1, 127)
                                                   : op_tab[$urandom_range(0, 5)];
                v  = ($urandom_range(0, 9) < 7);
            end
            step(v, op, st, bt);
            last_v   = v;
            last_rdy = !st || bt;
            last_op  = op;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
